load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before an access is abandoned.
REQ-002 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port MemRead, input, 1, which requests a load this instruction.
REQ-005 SHALL have port MemWrite, input, 1, which requests a store this instruction.
REQ-006 SHALL have port Load, input, 3, the load type: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; 101-111 are treated as lw.
REQ-007 SHALL have port Store, input, 2, the store type: 00 word, 01 half, 10 byte; 11 is treated as word.
REQ-008 SHALL have port Addr, input, 32, the byte address from the ALU.
REQ-009 SHALL have port WriteData, input, 32, the store source register.
REQ-010 SHALL have port ReadData, output, 32, the formatted, extended load result.
REQ-011 SHALL have port Stall, output, 1, which freezes the PC and pipeline while asserted.
REQ-012 SHALL have port misaligned, output, 1, which flags a misaligned access.
REQ-013 SHALL have port bus_err, output, 1, which flags an access that timed out.
REQ-014 SHALL have the data-memory bus ports mem_req (out 1), mem_we (out 1), mem_addr (out 32, word-aligned), mem_wdata (out 32), mem_be (out 4), mem_rdata (in 32) and mem_ack (in 1).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-016 SHALL define an access as MemRead|MemWrite; when both are set, MemWrite SHALL win and the access is a store.
REQ-017 SHALL treat lw/word with Addr[1:0]!=0 and lh/lhu/half with Addr[0]!=0 as misaligned.
REQ-018 SHALL, in IDLE on a misaligned access: combinationally set misaligned=1 and Stall=0, issue no bus request, suppress the write and drive ReadData=0.
REQ-019 SHALL, in IDLE on an aligned access: combinationally set Stall=1, latch Addr, WriteData, type and we, and go to WAIT.
REQ-020 SHALL, in WAIT: drive mem_req=1, Stall=1 and the latched mem_addr={addr[31:2],2'b00}, mem_we, mem_be and mem_wdata.
REQ-021 SHALL, on mem_ack in WAIT: capture mem_rdata into a register and go to DONE.
REQ-022 SHALL, in DONE: drive Stall=0 and present ReadData from the captured data for exactly one cycle, then return to IDLE.
REQ-023 SHALL give a minimum latency of 2 Stall cycles for an ack in the first WAIT cycle, plus one cycle per extra wait.
REQ-024 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES with no ack it SHALL go to DONE with bus_err=1 in that cycle and ReadData=0.
REQ-025 SHALL set store byte lanes: byte gives mem_be=1<<addr[1:0] and mem_wdata={4{WriteData[7:0]}}; half gives mem_be=addr[1]?1100:0011 and mem_wdata={2{WriteData[15:0]}}; word gives mem_be=1111.
REQ-026 SHALL format loads by shifting rdata right by 8*addr[1:0], then sign-extending (lb, lh) or zero-extending (lbu, lhu) from bit 7 or bit 15; lw passes the word unchanged.
REQ-027 SHALL drive mem_be=0000 and mem_req=0 outside WAIT.
REQ-028 SHALL drive ReadData with the last DONE value outside DONE.
REQ-029 SHALL ignore mem_ack outside WAIT.
REQ-030 SHALL, in DONE, not start a new access even if MemRead or MemWrite is still high; the core advances on the DONE edge.
REQ-031 SHALL reset the timeout counter on every entry to WAIT.

Reset
REQ-032 SHALL, on reset, enter IDLE, clear the latched fields, the counter and the ReadData register, and force Stall, misaligned, bus_err, mem_req, mem_we and mem_be to 0 while reset=1.
REQ-033 SHALL, on reset asserted in WAIT, drop mem_req on the next cycle; a late mem_ack arriving afterwards SHALL be ignored.

Verification
REQ-034 SHALL cover: lb at Addr=0x103, mem_rdata=0x80FF_1234, zero-wait ack -> Stall high for 2 cycles, mem_addr=0x100, DONE ReadData=0xFFFF_FF80.
REQ-035 SHALL cover: lhu at Addr=0x102, mem_rdata=0x9ABC_0000, ack after 3 wait cycles -> Stall high for 4 cycles, ReadData=0x0000_9ABC.
REQ-036 SHALL cover: sb at Addr=0x201 with WriteData=0x0000_00A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x200.
REQ-037 SHALL cover: lw at Addr=0x006 -> misaligned=1, Stall=0, mem_req never asserted, ReadData=0.
REQ-038 SHALL cover: TIMEOUT_CYCLES=4 with no ack -> WAIT for 4 cycles, then DONE with bus_err=1, ReadData=0, then IDLE.
REQ-039 SHALL cover: reset in the second WAIT cycle followed by mem_ack one cycle later -> IDLE, Stall=0, no DONE, ReadData=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: formats core loads/stores onto a word-wide req/ack data bus.
// Ports: core side (MemRead, MemWrite, Load, Store, Addr, WriteData ->
//   ReadData, Stall, misaligned, bus_err); bus side (mem_req, mem_we,
//   mem_addr, mem_wdata, mem_be <- mem_rdata, mem_ack).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT_CYCLES < 3) ? 1
                    : $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic [31:0]   last_q;

  logic          access;
  logic [1:0]    req_size;
  logic          req_sext;
  logic          req_mis;

  logic          lat_en;
  logic          cap_en;
  logic [31:0]   cap_data;
  logic          cap_err;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wd;
  logic [31:0]   shifted;
  logic [31:0]   fmt_rd;

  assign access = MemRead | MemWrite;

  // Decode the incoming request; a store wins over a load.
  always_comb begin
    req_size = SZ_W;
    req_sext = 1'b0;
    if (MemWrite) begin
      case (Store)
        2'b01:   req_size = SZ_H;
        2'b10:   req_size = SZ_B;
        default: req_size = SZ_W;
      endcase
    end else begin
      case (Load)
        3'b000: begin
          req_size = SZ_B;
          req_sext = 1'b1;
        end
        3'b001: begin
          req_size = SZ_H;
          req_sext = 1'b1;
        end
        3'b011:  req_size = SZ_B;
        3'b100:  req_size = SZ_H;
        default: req_size = SZ_W;
      endcase
    end
    req_mis = ((req_size == SZ_W) && (Addr[1:0] != 2'b00))
            || ((req_size == SZ_H) && Addr[0]);
  end

  // Byte lanes and replicated store data from the latched request.
  always_comb begin
    case (size_q)
      SZ_B: begin
        lane_be = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        lane_wd = wdata_q;
      end
    endcase
  end

  // Load formatting: align the addressed lane down, then extend.
  always_comb begin
    shifted = data_q >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_B: fmt_rd = sext_q ? {{24{shifted[7]}}, shifted[7:0]}
                            : {24'b0, shifted[7:0]};
      SZ_H: fmt_rd = sext_q ? {{16{shifted[15]}}, shifted[15:0]}
                            : {16'b0, shifted[15:0]};
      default: fmt_rd = shifted;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = lane_wd;

  always_comb begin
    state_d    = state_q;
    Stall      = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    ReadData   = last_q;
    lat_en     = 1'b0;
    cap_en     = 1'b0;
    cap_data   = 32'b0;
    cap_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (req_mis) begin
            misaligned = 1'b1;
            ReadData   = 32'b0;
          end else begin
            Stall   = 1'b1;
            lat_en  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        mem_be  = lane_be;
        if (mem_ack) begin
          cap_en   = 1'b1;
          cap_data = mem_rdata;
          state_d  = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the access; the result reads as zero.
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ReadData = fmt_rd;
        bus_err  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d    = IDLE;
      Stall      = 1'b0;
      misaligned = 1'b0;
      bus_err    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      ReadData   = 32'b0;
      lat_en     = 1'b0;
      cap_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_W;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (lat_en) begin
        addr_q  <= Addr;
        wdata_q <= WriteData;
        size_q  <= req_size;
        sext_q  <= req_sext;
        we_q    <= MemWrite;
        cnt_q   <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (cap_en) begin
        data_q <= cap_data;
        err_q  <= cap_err;
      end
      if (state_q == DONE) begin
        last_q <= fmt_rd;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table + scoreboard queue,
// plus hand sequences for reset behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, misaligned, bus_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Load(Load), .Store(Store),
    .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall),
    .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_at;
    int          e_stall;
    logic        e_mis;
    logic        e_err;
    logic        e_req;
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[15];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int stall = 0;
    int waits = 0;
    int cyc = 0;
    logic done = 0, mis = 0, err = 0, req = 0;
    logic leak = 0, we_s = 0;
    logic [31:0] rd = 0, ma = 0, wdo = 0;
    logic [3:0] be = 0;
    sb_q.push_back(v);
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr;
    Load = v.ld; Store = v.st;
    Addr = v.addr; WriteData = v.wd;
    mem_rdata = v.rdata;
    while (!done && cyc < 30) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      cyc++;
      if (mem_req) begin
        waits++;
        mem_ack = (waits == v.ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (Stall) stall++;
      if (misaligned) mis = 1;
      if (mem_req) begin
        req = 1; ma = mem_addr; be = mem_be;
        wdo = mem_wdata; we_s = mem_we;
      end else if (mem_be != 4'b0 || mem_we) begin
        leak = 1;
      end
      if (!Stall) begin
        done = 1; rd = ReadData; err = bus_err;
      end
    end
    MemRead = 0; MemWrite = 0; mem_ack = 0;
    e = sb_q.pop_front();
    chk($sformatf("v%0d done", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d stall", idx), stall, e.e_stall);
    chk($sformatf("v%0d mis", idx), {31'b0, mis}, {31'b0, e.e_mis});
    chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, e.e_err});
    chk($sformatf("v%0d req", idx), {31'b0, req}, {31'b0, e.e_req});
    chk($sformatf("v%0d leak", idx), {31'b0, leak}, 32'd0);
    if (e.e_req) begin
      chk($sformatf("v%0d maddr", idx), ma, e.e_maddr);
      chk($sformatf("v%0d we", idx), {31'b0, we_s}, {31'b0, e.wr});
    end
    if (e.e_req && e.wr) begin
      chk($sformatf("v%0d be", idx), {28'b0, be}, {28'b0, e.e_be});
      chk($sformatf("v%0d wdata", idx), wdo, e.e_wd);
    end
    if (!e.wr || e.e_mis)
      chk($sformatf("v%0d rdata", idx), rd, e.e_rd);
    if (!e.wr && !e.e_mis) begin
      @(posedge clk); #2;
      chk($sformatf("v%0d hold", idx), ReadData, e.e_rd);
    end
  endtask

  initial begin
    // rd wr ld st addr wd rdata ack stall mis err req maddr be wd rd
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 2'b00, 32'h103, 32'h0,
                32'h80FF1234, 1, 2, 1'b0, 1'b0, 1'b1, 32'h100,
                4'b0, 32'h0, 32'hFFFFFF80};
    tbl[1]  = '{1'b1, 1'b0, 3'b100, 2'b00, 32'h102, 32'h0,
                32'h9ABC0000, 3, 4, 1'b0, 1'b0, 1'b1, 32'h100,
                4'b0, 32'h0, 32'h00009ABC};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 2'b10, 32'h201, 32'h000000A5,
                32'h0, 1, 2, 1'b0, 1'b0, 1'b1, 32'h200,
                4'b0010, 32'hA5A5A5A5, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 2'b00, 32'h006, 32'h0,
                32'h0, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0,
                4'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b010, 2'b00, 32'h010, 32'h0,
                32'h55555555, 0, 5, 1'b0, 1'b1, 1'b1, 32'h010,
                4'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 2'b00, 32'h002, 32'h0,
                32'h80010000, 1, 2, 1'b0, 1'b0, 1'b1, 32'h000,
                4'b0, 32'h0, 32'hFFFF8001};
    tbl[6]  = '{1'b1, 1'b0, 3'b011, 2'b00, 32'h001, 32'h0,
                32'h0000F700, 1, 2, 1'b0, 1'b0, 1'b1, 32'h000,
                4'b0, 32'h0, 32'h000000F7};
    tbl[7]  = '{1'b1, 1'b0, 3'b010, 2'b00, 32'h004, 32'h0,
                32'hDEADBEEF, 2, 3, 1'b0, 1'b0, 1'b1, 32'h004,
                4'b0, 32'h0, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 1'b1, 3'b000, 2'b01, 32'h202, 32'h12345678,
                32'h0, 1, 2, 1'b0, 1'b0, 1'b1, 32'h200,
                4'b1100, 32'h56785678, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, 2'b00, 32'h300, 32'hCAFEF00D,
                32'h0, 1, 2, 1'b0, 1'b0, 1'b1, 32'h300,
                4'b1111, 32'hCAFEF00D, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b000, 2'b01, 32'h203, 32'h1111,
                32'h0, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0,
                4'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'b111, 2'b00, 32'h008, 32'h0,
                32'h12345678, 1, 2, 1'b0, 1'b0, 1'b1, 32'h008,
                4'b0, 32'h0, 32'h12345678};
    tbl[12] = '{1'b1, 1'b1, 3'b010, 2'b10, 32'h003, 32'h0000005A,
                32'h0, 1, 2, 1'b0, 1'b0, 1'b1, 32'h000,
                4'b1000, 32'h5A5A5A5A, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 3'b000, 2'b11, 32'h002, 32'h1,
                32'h0, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0,
                4'b0, 32'h0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'b000, 2'b00, 32'h000, 32'h0,
                32'h0000007F, 2, 3, 1'b0, 1'b0, 1'b1, 32'h000,
                4'b0, 32'h0, 32'h0000007F};

    reset = 1; MemRead = 0; MemWrite = 0; Load = 0; Store = 0;
    Addr = 0; WriteData = 0; mem_rdata = 0; mem_ack = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst stall", {31'b0, Stall}, 32'd0);
    chk("rst req", {31'b0, mem_req}, 32'd0);
    chk("rst be", {28'b0, mem_be}, 32'd0);
    chk("rst mis", {31'b0, misaligned}, 32'd0);
    chk("rst err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("rst rdata", ReadData, 32'd0);

    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

    // Reset during the second WAIT cycle, then a late ack.
    @(posedge clk); #1;
    MemRead = 1; Load = 3'b010; Addr = 32'h40;
    mem_rdata = 32'h11111111;
    #1 chk("r idle stall", {31'b0, Stall}, 32'd1);
    @(posedge clk); #2;
    chk("r wait1 req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("r wait2 stall", {31'b0, Stall}, 32'd0);
    chk("r wait2 req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 0; MemRead = 0; mem_ack = 1;
    #1;
    chk("r after req", {31'b0, mem_req}, 32'd0);
    chk("r after stall", {31'b0, Stall}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_ack = 0;
      #1;
      chk("r no done stall", {31'b0, Stall}, 32'd0);
      chk("r no done rdata", ReadData, 32'd0);
      chk("r no done err", {31'b0, bus_err}, 32'd0);
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
